// File: rtl/codec_spi_config_if.sv
// ---------------------------------------------------------------------------
// codec_spi_config_if
// Request channel between a configuration sequencer and the codec SPI
// write master.  One transfer happens on every rising clock edge where
// cfg_valid and cfg_ready are both high.
//
//   cfg_valid  sequencer -> master   write request present
//   cfg_ready  master -> sequencer   master can take a request this cycle
//   cfg_addr   sequencer -> master   16-bit codec register address
//   cfg_data   sequencer -> master   8-bit register data
//   cfg_last   sequencer -> master   final write of the configuration sequence
// ---------------------------------------------------------------------------
interface codec_spi_config_if;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_addr;
   logic [7:0]  cfg_data;
   logic        cfg_last;

   // The sequencer side drives requests and watches ready.
   modport master (
      output cfg_valid,
      output cfg_addr,
      output cfg_data,
      output cfg_last,
      input  cfg_ready
   );

   // The SPI write master consumes requests and drives ready.
   modport slave (
      input  cfg_valid,
      input  cfg_addr,
      input  cfg_data,
      input  cfg_last,
      output cfg_ready
   );
endinterface

// File: rtl/codec_spi_config.sv
// ---------------------------------------------------------------------------
// codec_spi_config
// Single-clock SPI (mode 0) write master that streams codec register writes.
// After reset it sends a short train of chip-select pulses that put the codec
// into SPI mode.  It then accepts register writes, shifts each one out as a
// 32-bit frame {8'h00, addr, data} MSB first, and after the write marked
// "last" raises a sticky done flag that enables the audio path.
//
// Parameters
//   CLK_DIV          SCLK half-period in i_clock cycles (2 or more)
//   GAP_CYCLES       cycles cs_n stays high after every frame (1 or more)
//   PREAMBLE_PULSES  number of mode-select cs_n pulses after reset (1 or more)
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   cfg            request channel (valid/ready/addr/data/last), slave side
//   o_spi_cs_n     SPI chip select, active low
//   o_spi_sclk     SPI clock, idles low
//   o_spi_mosi     SPI data, MSB first
//   o_busy         high whenever the block is neither idle nor done
//   o_config_done  sticky, high once the last frame and its gap have finished
// ---------------------------------------------------------------------------
module codec_spi_config #(
   parameter int CLK_DIV         = 4,
   parameter int GAP_CYCLES      = 8,
   parameter int PREAMBLE_PULSES = 3
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   codec_spi_config_if.slave  cfg,
   output logic               o_spi_cs_n,
   output logic               o_spi_sclk,
   output logic               o_spi_mosi,
   output logic               o_busy,
   output logic               o_config_done
);

   // One shared counter covers the preamble period, the SCLK half-period
   // divider, the trailing half-period and the inter-frame gap.
   localparam int PRE_LEN = 4 * CLK_DIV;
   localparam int CNT_MAX = (PRE_LEN > GAP_CYCLES) ? PRE_LEN : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PULSE_W = $clog2(PREAMBLE_PULSES + 1);

   localparam logic [CNT_W-1:0]   PRE_END     = CNT_W'(PRE_LEN);
   localparam logic [CNT_W-1:0]   PRE_LOW_END = CNT_W'(2 * CLK_DIV);
   localparam logic [CNT_W-1:0]   DIV_END     = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]   GAP_END     = CNT_W'(GAP_CYCLES - 1);
   localparam logic [PULSE_W-1:0] PULSE_END   = PULSE_W'(PREAMBLE_PULSES - 1);
   localparam logic [5:0]         LAST_EDGE   = 6'd63;

   typedef enum logic [2:0] {
      ST_PREAMBLE,
      ST_IDLE,
      ST_SHIFT,
      ST_TRAIL,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [5:0]         edge_q, edge_d;
   logic [PULSE_W-1:0] pulse_q, pulse_d;
   logic [31:0]        shreg_q, shreg_d;
   logic               last_q, last_d;

   logic cs_n_d, sclk_d, mosi_d, ready_d, busy_d, done_d;
   logic ready_q;

   assign cfg.cfg_ready = ready_q;

   // State register.  Every output is a flop loaded from the value the
   // output logic derives for the *next* state, so the pins are glitch-free
   // and always match the state the block is in during that cycle.  Reset
   // parks the sequencer one step before the first preamble pulse, so the
   // first edge after release already drives cs_n low and o_busy high.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q       <= ST_PREAMBLE;
         cnt_q         <= '0;
         edge_q        <= '0;
         pulse_q       <= '0;
         shreg_q       <= '0;
         last_q        <= 1'b0;
         o_spi_cs_n    <= 1'b1;
         o_spi_sclk    <= 1'b0;
         o_spi_mosi    <= 1'b0;
         ready_q       <= 1'b0;
         o_busy        <= 1'b0;
         o_config_done <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         edge_q        <= edge_d;
         pulse_q       <= pulse_d;
         shreg_q       <= shreg_d;
         last_q        <= last_d;
         o_spi_cs_n    <= cs_n_d;
         o_spi_sclk    <= sclk_d;
         o_spi_mosi    <= mosi_d;
         ready_q       <= ready_d;
         o_busy        <= busy_d;
         o_config_done <= done_d;
      end
   end

   // Next-state logic.
   // PREAMBLE: cnt runs 1..4*CLK_DIV per pulse (0 only right after reset);
   //   the low half of each pulse is cnt 1..2*CLK_DIV.
   // SHIFT: cnt divides the clock into SCLK half-periods and edge_q counts
   //   the 64 half-periods; odd edge_q means SCLK is high.  The shift
   //   register advances only when leaving an odd half-period, i.e. on the
   //   SCLK falling edge, so the MSB is stable around every rising edge.
   // TRAIL: one more half-period with SCLK low and cs_n still asserted.
   // GAP: cs_n high for GAP_CYCLES, then IDLE or the terminal DONE state.
   // The request inputs are only looked at in IDLE, which is the one state
   // where ready is high, so a running frame can never be disturbed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      edge_d  = edge_q;
      pulse_d = pulse_q;
      shreg_d = shreg_q;
      last_d  = last_q;

      case (state_q)
         ST_PREAMBLE: begin
            if (cnt_q == PRE_END) begin
               if (pulse_q == PULSE_END) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  pulse_d = '0;
               end else begin
                  cnt_d   = CNT_W'(1);
                  pulse_d = pulse_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_IDLE: begin
            if (cfg.cfg_valid) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               edge_d  = '0;
               shreg_d = {8'h00, cfg.cfg_addr, cfg.cfg_data};
               last_d  = cfg.cfg_last;
            end
         end

         ST_SHIFT: begin
            if (cnt_q == DIV_END) begin
               cnt_d = '0;
               if (edge_q == LAST_EDGE) begin
                  state_d = ST_TRAIL;
               end else begin
                  edge_d = edge_q + 1'b1;
                  if (edge_q[0]) begin
                     shreg_d = {shreg_q[30:0], 1'b0};
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_TRAIL: begin
            if (cnt_q == DIV_END) begin
               state_d = ST_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_GAP: begin
            if (cnt_q == GAP_END) begin
               state_d = last_q ? ST_DONE : ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_DONE;
         end

         default: begin
            state_d = ST_PREAMBLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic, evaluated on the next state so the registered pins line
   // up with the state they describe.  SPI pins default to the idle bus:
   // cs_n high, sclk and mosi low.
   always_comb begin
      cs_n_d  = 1'b1;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;

      case (state_d)
         ST_PREAMBLE: begin
            cs_n_d = (cnt_d == '0) || (cnt_d > PRE_LOW_END);
         end

         ST_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end

         ST_SHIFT: begin
            cs_n_d = 1'b0;
            sclk_d = edge_d[0];
            mosi_d = shreg_d[31];
         end

         ST_TRAIL: begin
            cs_n_d = 1'b0;
         end

         ST_GAP: begin
            cs_n_d = 1'b1;
         end

         ST_DONE: begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end

         default: begin
            cs_n_d = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_codec_spi_config.sv
// ---------------------------------------------------------------------------
// tb_codec_spi_config
// Self-checking bench for codec_spi_config with CLK_DIV=4, GAP_CYCLES=8,
// PREAMBLE_PULSES=3.  The stimulus side pushes each expected 32-bit frame
// into a queue at handshake time; an SPI slave model decodes frames from the
// pins and pops/compares them when chip select rises.
// ---------------------------------------------------------------------------
module tb_codec_spi_config;

   localparam int CLK_DIV      = 4;
   localparam int GAP_CYCLES   = 8;
   localparam int PRE_PULSES   = 3;
   localparam int FRAME_LOW    = 65 * CLK_DIV;
   localparam int ACCEPT_DELAY = 65 * CLK_DIV + GAP_CYCLES;

   logic i_clock   = 1'b0;
   logic i_reset_n = 1'b0;
   logic o_spi_cs_n, o_spi_sclk, o_spi_mosi, o_busy, o_config_done;

   codec_spi_config_if cfg_bus ();

   int check_count = 0;
   int pass_count  = 0;
   int cyc         = 0;
   int frame_count = 0;
   logic [31:0] sb_q[$];

   codec_spi_config #(
      .CLK_DIV         (CLK_DIV),
      .GAP_CYCLES      (GAP_CYCLES),
      .PREAMBLE_PULSES (PRE_PULSES)
   ) dut (
      .i_clock       (i_clock),
      .i_reset_n     (i_reset_n),
      .cfg           (cfg_bus),
      .o_spi_cs_n    (o_spi_cs_n),
      .o_spi_sclk    (o_spi_sclk),
      .o_spi_mosi    (o_spi_mosi),
      .o_busy        (o_busy),
      .o_config_done (o_config_done)
   );

   // 100 MHz clock.
   always #5 i_clock = ~i_clock;

   // Cycle index: between posedge n and posedge n+1 this reads n.
   always @(posedge i_clock) cyc <= cyc + 1;

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", check_count);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // SPI slave model and scoreboard monitor.  Samples on the falling clock
   // edge, shifts MOSI in on every SCLK rise, and on chip-select rise either
   // ignores a preamble pulse (no SCLK edges) or checks a complete frame.
   initial begin : spi_monitor
      logic        prev_cs;
      logic        prev_sclk;
      logic        frame_seen;
      int          low_len;
      int          high_len;
      int          gap_before;
      int          bit_cnt;
      logic [31:0] rx_word;
      logic [31:0] exp_word;
      prev_cs    = 1'b1;
      prev_sclk  = 1'b0;
      frame_seen = 1'b0;
      low_len    = 0;
      high_len   = 0;
      gap_before = 0;
      bit_cnt    = 0;
      rx_word    = '0;
      forever begin
         @(negedge i_clock);
         if (!i_reset_n) begin
            prev_cs    = 1'b1;
            prev_sclk  = 1'b0;
            frame_seen = 1'b0;
            low_len    = 0;
            high_len   = 0;
            bit_cnt    = 0;
         end else begin
            if (!o_spi_cs_n) begin
               if (prev_cs) begin
                  gap_before = high_len;
                  low_len    = 0;
                  bit_cnt    = 0;
               end
               low_len++;
               if (o_spi_sclk && !prev_sclk) begin
                  rx_word = {rx_word[30:0], o_spi_mosi};
                  bit_cnt++;
               end
            end else begin
               if (!prev_cs && bit_cnt > 0) begin
                  frame_count++;
                  if (sb_q.size() == 0) begin
                     check_output("unexpected_frame", rx_word, 32'hFFFF_FFFF);
                  end else begin
                     exp_word = sb_q.pop_front();
                     check_output("frame_data", rx_word, exp_word);
                     check_output("frame_bits", 32'(bit_cnt), 32'd32);
                     check_output("frame_cs_low", 32'(low_len), 32'(FRAME_LOW));
                  end
                  if (frame_seen)
                     check_output("frame_gap_ok", 32'(gap_before >= GAP_CYCLES), 32'd1);
                  frame_seen = 1'b1;
               end
               if (!prev_cs) high_len = 0;
               high_len++;
            end
            prev_cs   = o_spi_cs_n;
            prev_sclk = o_spi_sclk;
         end
      end
   end

   // Watch the preamble right after reset release: three 8-cycle lows with
   // 8-cycle highs, no SCLK/MOSI activity, busy from the first cycle, and
   // ready first seen in cycle 49 after release.
   task automatic check_preamble();
      int   low_runs = 0;
      int   bad_runs = 0;
      int   run      = 0;
      int   activity = 0;
      int   ready_at = -1;
      logic prev_cs  = 1'b1;
      logic busy_first = 1'b0;
      for (int n = 1; n <= 100 && ready_at < 0; n++) begin
         @(negedge i_clock);
         if (n == 1) busy_first = o_busy;
         if (cfg_bus.cfg_ready) begin
            ready_at = n;
         end else begin
            if (o_spi_sclk || o_spi_mosi) activity++;
            if (n > 1 && o_spi_cs_n != prev_cs) begin
               if (run != 2 * CLK_DIV) bad_runs++;
               run = 0;
            end
            if (!o_spi_cs_n && prev_cs) low_runs++;
            run++;
            prev_cs = o_spi_cs_n;
         end
      end
      if (run != 2 * CLK_DIV) bad_runs++;
      check_output("pre_busy_first", 32'(busy_first), 32'd1);
      check_output("pre_pulses", 32'(low_runs), 32'(PRE_PULSES));
      check_output("pre_run_lengths_bad", 32'(bad_runs), 32'd0);
      check_output("pre_sclk_mosi_activity", 32'(activity), 32'd0);
      check_output("pre_ready_cycle", 32'(ready_at), 32'd49);
   endtask

   // Assert reset at a falling edge and check the forced output values.
   task automatic assert_reset();
      @(negedge i_clock);
      i_reset_n = 1'b0;
      #1;
      check_output("reset_outputs",
                   32'({o_spi_cs_n, o_spi_sclk, o_spi_mosi, cfg_bus.cfg_ready, o_busy, o_config_done}),
                   32'h20);
      repeat (2) @(negedge i_clock);
   endtask

   task automatic release_reset();
      @(negedge i_clock);
      i_reset_n = 1'b1;
      check_preamble();
   endtask

   // Present a request and hold it until the handshake edge; the expected
   // frame goes into the scoreboard.  Returns the handshake cycle index and
   // leaves valid high (callers decide when to drop it).
   task automatic apply_stimulus(input logic [15:0] addr, input logic [7:0] data,
                                 input logic last, input logic [31:0] expected,
                                 output int hs_cycle);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_addr  = addr;
      cfg_bus.cfg_data  = data;
      cfg_bus.cfg_last  = last;
      hs_cycle = -1;
      for (int n = 0; n < 2000 && hs_cycle < 0; n++) begin
         if (cfg_bus.cfg_ready) begin
            hs_cycle = cyc;
            sb_q.push_back(expected);
         end
         @(negedge i_clock);
      end
      if (hs_cycle < 0) check_output("handshake_timeout", 32'd0, 32'd1);
   endtask

   // Check done rises exactly ACCEPT_DELAY cycles after the last frame's t0.
   task automatic check_done_timing(input int hs_cycle);
      while (cyc < hs_cycle + ACCEPT_DELAY) @(negedge i_clock);
      check_output("done_not_early", 32'(o_config_done), 32'd0);
      @(negedge i_clock);
      check_output("done_set", 32'(o_config_done), 32'd1);
      check_output("done_ready_low", 32'(cfg_bus.cfg_ready), 32'd0);
      check_output("done_busy_low", 32'(o_busy), 32'd0);
      check_output("scoreboard_drained", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin : main
      int hs1;
      int hs2;
      int activity;
      int ready_seen;
      int fc0;
      int rises;
      logic prev_sclk;

      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_addr  = '0;
      cfg_bus.cfg_data  = '0;
      cfg_bus.cfg_last  = 1'b0;

      // Power-on reset and preamble.
      repeat (3) @(negedge i_clock);
      check_output("reset_outputs_por",
                   32'({o_spi_cs_n, o_spi_sclk, o_spi_mosi, cfg_bus.cfg_ready, o_busy, o_config_done}),
                   32'h20);
      release_reset();

      // Back-to-back writes with valid held high throughout.
      apply_stimulus(16'h4015, 8'h01, 1'b0, 32'h0040_1501, hs1);
      apply_stimulus(16'h40F9, 8'h7F, 1'b1, 32'h0040_F97F, hs2);
      cfg_bus.cfg_valid = 1'b0;
      check_output("b2b_accept_delay", 32'(hs2 - (hs1 + 1)), 32'(ACCEPT_DELAY));
      check_done_timing(hs2);

      // Requests after done must be ignored.
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_addr  = 16'h4002;
      cfg_bus.cfg_data  = 8'hA5;
      cfg_bus.cfg_last  = 1'b0;
      activity   = 0;
      ready_seen = 0;
      repeat (40) begin
         @(negedge i_clock);
         if (!o_spi_cs_n || o_spi_sclk || o_spi_mosi) activity++;
         if (cfg_bus.cfg_ready) ready_seen++;
      end
      cfg_bus.cfg_valid = 1'b0;
      check_output("after_done_spi_activity", 32'(activity), 32'd0);
      check_output("after_done_ready", 32'(ready_seen), 32'd0);
      check_output("after_done_sticky", 32'(o_config_done), 32'd1);

      // Single last write.
      assert_reset();
      release_reset();
      apply_stimulus(16'h4000, 8'h01, 1'b1, 32'h0040_0001, hs1);
      cfg_bus.cfg_valid = 1'b0;
      check_done_timing(hs1);

      // Inputs wiggling while busy must not change the frame or add one.
      assert_reset();
      release_reset();
      fc0 = frame_count;
      apply_stimulus(16'h1234, 8'hAB, 1'b0, 32'h0012_34AB, hs1);
      for (int n = 0; n < 200; n++) begin
         cfg_bus.cfg_valid = 1'($urandom_range(0, 1));
         cfg_bus.cfg_addr  = 16'($urandom);
         cfg_bus.cfg_data  = 8'($urandom);
         cfg_bus.cfg_last  = 1'($urandom_range(0, 1));
         @(negedge i_clock);
      end
      cfg_bus.cfg_valid = 1'b0;
      while (cyc < hs1 + ACCEPT_DELAY + 3) @(negedge i_clock);
      check_output("busy_noise_frame_count", 32'(frame_count - fc0), 32'd1);
      check_output("busy_noise_ready_back", 32'(cfg_bus.cfg_ready), 32'd1);
      check_output("busy_noise_not_done", 32'(o_config_done), 32'd0);

      // Reset in the middle of a frame, at the 17th SCLK rising edge.
      apply_stimulus(16'h4015, 8'h55, 1'b0, 32'h0040_1555, hs1);
      cfg_bus.cfg_valid = 1'b0;
      rises     = 0;
      prev_sclk = 1'b0;
      for (int n = 0; n < 400 && rises < 17; n++) begin
         if (o_spi_sclk && !prev_sclk) rises++;
         prev_sclk = o_spi_sclk;
         if (rises < 17) @(negedge i_clock);
      end
      check_output("abort_sclk_rises", 32'(rises), 32'd17);
      i_reset_n = 1'b0;
      #1;
      check_output("abort_pins_forced", 32'({o_spi_cs_n, o_spi_sclk}), 32'h2);
      sb_q.delete();
      activity = 0;
      repeat (10) begin
         @(negedge i_clock);
         if (!o_spi_cs_n || o_spi_sclk || o_spi_mosi) activity++;
      end
      check_output("abort_no_activity", 32'(activity), 32'd0);
      release_reset();

      // One full frame after the aborted one to show the block recovered.
      apply_stimulus(16'h40F9, 8'h7F, 1'b1, 32'h0040_F97F, hs1);
      cfg_bus.cfg_valid = 1'b0;
      check_done_timing(hs1);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/codec_spi_config.md
CODEC_SPI_CONFIG -- requirements
Module: codec_spi_config

Interface
REQ-001 Block SHALL be a single-clock SPI write master that streams codec register writes (one clock, asynchronous active-low reset) and asserts a done flag that enables the audio path.
REQ-002 Parameter CLK_DIV, default 4, SHALL set the SCLK half-period in i_clock cycles; legal values are 2 or greater.
REQ-003 Parameter GAP_CYCLES, default 8, SHALL set the minimum number of i_clock cycles o_spi_cs_n stays high between frames.
REQ-004 Parameter PREAMBLE_PULSES, default 3, SHALL set the number of mode-select CS low pulses issued after reset.
REQ-005 i_clock  input  1  system clock; all logic SHALL be on its rising edge.
REQ-006 i_reset_n  input  1  asynchronous active-low reset.
REQ-007 i_cfg_valid  input  1  write request present.
REQ-008 o_cfg_ready  output  1  block accepts a request; transfer occurs when valid and ready are both 1.
REQ-009 i_cfg_addr  input  16  codec register address.
REQ-010 i_cfg_data  input  8  register data.
REQ-011 i_cfg_last  input  1  marks the final write of the sequence.
REQ-012 o_spi_cs_n  output  1  SPI chip select, active low.
REQ-013 o_spi_sclk  output  1  SPI clock, idle low (mode 0).
REQ-014 o_spi_mosi  output  1  SPI data, MSB first.
REQ-015 o_busy  output  1  high whenever state is not IDLE or DONE.
REQ-016 o_config_done  output  1  sticky; high after the last frame completes.

Function
REQ-017 States SHALL be PREAMBLE, IDLE, SHIFT, TRAIL, GAP and DONE; reset SHALL enter PREAMBLE.
REQ-018 In PREAMBLE, block SHALL emit PREAMBLE_PULSES pulses, each being cs_n low for 2*CLK_DIV cycles then high for 2*CLK_DIV cycles, with sclk held 0 and mosi held 0; it SHALL then enter IDLE.
REQ-019 o_cfg_ready SHALL be 1 only in IDLE.
REQ-020 On handshake, block SHALL capture frame = {8'h00, i_cfg_addr, i_cfg_data} (32 bits) and last flag, and enter SHIFT.
REQ-021 Inputs SHALL be ignored outside the handshake cycle.
REQ-022 Let t0 be the cycle after the handshake. cs_n SHALL go 0 and mosi SHALL equal frame[31] at t0.
REQ-023 For k=0..31, sclk SHALL rise at t0+CLK_DIV*(2k+1) and fall at t0+CLK_DIV*(2k+2).
REQ-024 mosi SHALL update to the next bit only on sclk falling edges, so bit 31-k is stable across rising edge k.
REQ-025 After the 32nd falling edge (TRAIL), sclk SHALL stay 0 and cs_n SHALL rise at t0+65*CLK_DIV; mosi SHALL return to 0.
REQ-026 GAP SHALL hold cs_n high for GAP_CYCLES cycles, then go to IDLE if the captured last flag is 0, else DONE.
REQ-027 o_cfg_ready SHALL therefore reassert at t0+65*CLK_DIV+GAP_CYCLES.
REQ-028 In DONE, o_config_done SHALL be 1, ready 0, and cs_n/sclk/mosi SHALL be 1/0/0; DONE SHALL be left only by reset.
REQ-029 A frame in progress SHALL never be shortened or aborted except by reset.
REQ-030 All outputs SHALL be registered (glitch-free SPI pins).

Reset
REQ-031 Asserting i_reset_n=0 at any time, including mid-frame, SHALL immediately force o_spi_cs_n=1, o_spi_sclk=0, o_spi_mosi=0, o_cfg_ready=0, o_busy=0, o_config_done=0, and clear all counters.
REQ-032 After release, PREAMBLE SHALL rerun in full, and o_busy SHALL be 1 from the first cycle after release.

Verification (CLK_DIV=4, GAP_CYCLES=8, PREAMBLE_PULSES=3)
REQ-033 Release reset -> exactly 3 cs_n low pulses of 8 cycles separated by 8-cycle highs, sclk constant 0, then o_cfg_ready=1.
REQ-034 Single write addr 16'h4000, data 8'h01, last=1 -> SPI slave model decodes 32'h00400001 MSB first, cs_n low for 260 cycles, then after 8 cycles o_config_done=1 and ready stays 0.
REQ-035 Back-to-back writes (16'h4015/8'h01, 16'h40F9/8'h7F last) with valid held continuously -> two frames, cs_n high of at least 8 cycles between them, second accepted exactly 268 cycles after the first frame's t0.
REQ-036 Valid toggled and inputs changed while busy -> frame contents equal the values captured at the handshake; no extra frame is produced.
REQ-037 Reset asserted at the 17th sclk rising edge -> cs_n=1 and sclk=0 in the same cycle, no further edges, PREAMBLE restarts after release.
REQ-038 Valid asserted after done -> no SPI activity; o_config_done stays 1.
